bufz_bus_ctrl: RTL and testbench

BUFZ_BUS_CTRL -- requirements
Module: bufz_bus_ctrl

---
 rtl/bufz_bus_pkg.sv | 36 +++
 rtl/bufz_bus_rr_arb.sv | 31 +++
 rtl/bufz_bus_ctrl.sv | 149 ++++++++++++++
 tb/tb_bufz_bus_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bufz_bus_pkg.sv
// Shared types and constants for the tri-state bus controller.
package bufz_bus_pkg;

    // Bus ownership phases: arbitrate, own the bus, release it.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    // Legal parameter ranges.
    localparam int NCH_MIN  = 2;
    localparam int NCH_MAX  = 16;
    localparam int W_MIN    = 1;
    localparam int W_MAX    = 32;
    localparam int TA_MIN   = 1;
    localparam int TA_MAX   = 7;
    localparam int MAXB_MIN = 1;
    localparam int MAXB_MAX = 255;

    // Default burst limit and turnaround length.
    localparam int MAXB_DEF = 16;
    localparam int TA_DEF   = 2;

    // Bits needed for a counter that must hold the value max_count.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

    // Counter widths for the defaults and for the widest legal settings.
    localparam int BURST_W_DEF = cnt_width(MAXB_DEF);
    localparam int TURN_W_DEF  = cnt_width(TA_DEF);
    localparam int BURST_W_MAX = cnt_width(MAXB_MAX);
    localparam int TURN_W_MAX  = cnt_width(TA_MAX);

endpackage

// File: rtl/bufz_bus_rr_arb.sv
// Round-robin picker: the first requester at or after ptr, wrapping, wins.
module bufz_bus_rr_arb #(
    parameter int NCH = 4,
    parameter int PW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [NCH-1:0] win
);

    // Scan channels in priority order starting at ptr; keep the first hit.
    always_comb begin
        logic [PW:0] pos;
        logic        found;
        // NOTE: every output gets a default before any branch so no latch is inferred.
        win   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 0; i < NCH; i++) begin
            pos = {1'b0, ptr} + (PW + 1)'(i);
            if (pos >= (PW + 1)'(NCH)) begin
                pos = pos - (PW + 1)'(NCH);
            end
            if (!found && req[pos[PW-1:0]]) begin
                win[pos[PW-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bufz_bus_ctrl.sv
// Tri-state bus controller: round-robin ownership, bounded bursts, and a
// released turnaround gap between successive owners.
module bufz_bus_ctrl
    import bufz_bus_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int W    = 8,
    parameter int TA   = TA_DEF,
    parameter int MAXB = MAXB_DEF
) (
    input  logic           CLK,
    input  logic           RN,
    input  logic           EN,
    input  logic [NCH-1:0] REQ,
    input  logic [NCH*W-1:0] D,
    output tri   [W-1:0]   Z,
    output logic           OE,
    output logic [NCH-1:0] GNT,
    output logic [W-1:0]   ZH,
    output logic           BUSY
);

    localparam int PW  = $clog2(NCH);
    localparam int BCW = cnt_width(MAXB);
    localparam int TCW = cnt_width(TA);

    // Reject out-of-range parameters while elaborating.
    if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
        $error("bufz_bus_ctrl: NCH=%0d outside %0d..%0d", NCH, NCH_MIN, NCH_MAX);
    end
    if (W < W_MIN || W > W_MAX) begin : g_bad_w
        $error("bufz_bus_ctrl: W=%0d outside %0d..%0d", W, W_MIN, W_MAX);
    end
    if (TA < TA_MIN || TA > TA_MAX) begin : g_bad_ta
        $error("bufz_bus_ctrl: TA=%0d outside %0d..%0d", TA, TA_MIN, TA_MAX);
    end
    if (MAXB < MAXB_MIN || MAXB > MAXB_MAX) begin : g_bad_maxb
        $error("bufz_bus_ctrl: MAXB=%0d outside %0d..%0d", MAXB, MAXB_MIN, MAXB_MAX);
    end

    state_t         state_q, state_d;
    logic [NCH-1:0] gnt_q, gnt_d;
    logic [PW-1:0]  own_q, own_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [BCW-1:0] burst_q, burst_d;
    logic [TCW-1:0] turn_q, turn_d;
    logic [W-1:0]   zh_q;
    logic [NCH-1:0] win;
    logic [PW-1:0]  win_idx;
    logic [W-1:0]   d_sel;

    bufz_bus_rr_arb #(.NCH(NCH), .PW(PW)) u_arb (
        .req (REQ),
        .ptr (ptr_q),
        .win (win)
    );

    // Convert the one-hot winner to an index and select the owner's data.
    always_comb begin
        win_idx = '0;
        d_sel   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (win[i]) begin
                win_idx = PW'(i);
            end
            if (own_q == PW'(i)) begin
                d_sel = D[i*W +: W];
            end
        end
    end

    // Next-state logic: grant from IDLE, release from DRIVE, time out TURN.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        turn_d  = turn_q;
        case (state_q)
            ST_IDLE: begin
                if (EN && (|REQ)) begin
                    state_d = ST_DRIVE;
                    gnt_d   = win;
                    own_d   = win_idx;
                    // The pointer moves past this winner exactly once per grant.
                    ptr_d   = (win_idx == PW'(NCH - 1)) ? '0 : win_idx + 1'b1;
                    burst_d = BCW'(1);
                end
            end
            ST_DRIVE: begin
                // Any combination of release causes collapses into one transition.
                if (!REQ[own_q] || !EN || (burst_q == BCW'(MAXB))) begin
                    state_d = ST_TURN;
                    gnt_d   = '0;
                    burst_d = '0;
                    turn_d  = TCW'(1);
                end else begin
                    burst_d = burst_q + 1'b1;
                end
            end
            ST_TURN: begin
                if (turn_q == TCW'(TA)) begin
                    state_d = ST_IDLE;
                    turn_d  = '0;
                end else begin
                    turn_d = turn_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                burst_d = '0;
                turn_d  = '0;
            end
        endcase
    end

    // State, grant and counter registers; reset releases the bus at once.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            own_q   <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
            turn_q  <= '0;
            zh_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            gnt_q   <= gnt_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            turn_q  <= turn_d;
            if (state_q == ST_DRIVE) begin
                zh_q <= d_sel;
            end
        end
    end

    assign GNT  = gnt_q;
    assign OE   = |gnt_q;
    assign ZH   = zh_q;
    assign BUSY = (state_q != ST_IDLE);
    assign Z    = OE ? d_sel : {W{1'bz}};

endmodule

// File: tb/tb_bufz_bus_ctrl.sv
// Directed bench for bufz_bus_ctrl: reset, single owner, fairness, EN drop,
// async reset mid-burst, and a sole requester at a small burst limit.
module tb_bufz_bus_ctrl;

    localparam int NCH = 4;
    localparam int W   = 8;

    // Per-channel data driven on the main instance.
    localparam logic [W-1:0] DV0 = 8'h11;
    localparam logic [W-1:0] DV1 = 8'h22;
    localparam logic [W-1:0] DV2 = 8'hA5;
    localparam logic [W-1:0] DV3 = 8'h3C;

    logic             clk = 1'b0;
    logic             rn;
    logic             en, en_b;
    logic [NCH-1:0]   req, req_b;
    logic [NCH*W-1:0] d, d_b;
    wire  [W-1:0]     z_bus, z_b;
    logic             oe, oe_b, busy, busy_b;
    logic [NCH-1:0]   gnt, gnt_b;
    logic [W-1:0]     zh, zh_b;
    logic [W-1:0]     dv [NCH];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bufz_bus_ctrl #(.NCH(NCH), .W(W), .TA(2), .MAXB(16)) dut (
        .CLK(clk), .RN(rn), .EN(en), .REQ(req), .D(d),
        .Z(z_bus), .OE(oe), .GNT(gnt), .ZH(zh), .BUSY(busy)
    );

    bufz_bus_ctrl #(.NCH(NCH), .W(W), .TA(2), .MAXB(4)) dut_b (
        .CLK(clk), .RN(rn), .EN(en_b), .REQ(req_b), .D(d_b),
        .Z(z_b), .OE(oe_b), .GNT(gnt_b), .ZH(zh_b), .BUSY(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Released bus: z in a 4-state simulator; a 2-state one resolves it to 0,
    // so all driven data used here is nonzero.
    function automatic logic is_hiz(input logic [W-1:0] v);
        return (v === {W{1'bz}}) || (v === {W{1'b0}});
    endfunction

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ok;
        int bad;
        logic [NCH-1:0] exp_g;
        logic [NCH-1:0] tbl_gnt  [8];
        logic           tbl_busy [8];

        dv[0] = DV0; dv[1] = DV1; dv[2] = DV2; dv[3] = DV3;
        rn    = 1'b0;
        en    = 1'b1;
        en_b  = 1'b1;
        req   = 4'b1111;
        req_b = 4'b0000;
        d     = {DV3, DV2, DV1, DV0};
        d_b   = {24'h0, 8'h5A};

        // Reset held with all channels requesting.
        step();
        step();
        check("rst_z_hiz", 32'(is_hiz(z_bus)), 1);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_oe", 32'(oe), 0);
        check("rst_zh", 32'(zh), 0);
        check("rst_busy", 32'(busy), 0);

        // Fairness: grants 0,1,2,3,0, 16 cycles each, 3 released cycles between.
        rn  = 1'b1;
        bad = 0;
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << (g % NCH);
            ok = 0;
            for (int c = 0; c < 16; c++) begin
                step();
                if (gnt === exp_g && oe === 1'b1 && z_bus === dv[g % NCH]) ok++;
                if (!$onehot0(gnt) || oe !== (|gnt)) bad++;
            end
            check($sformatf("fair_grant%0d", g), ok, 16);
            if (g < 4) begin
                ok = 0;
                for (int c = 0; c < 3; c++) begin
                    step();
                    if (gnt === 4'b0000 && oe === 1'b0 && is_hiz(z_bus)) ok++;
                    if (!$onehot0(gnt) || oe !== (|gnt)) bad++;
                end
                check($sformatf("fair_gap%0d", g), ok, 3);
            end
        end
        check("fair_onehot", bad, 0);
        req = 4'b0000;
        step();
        step();
        step();
        check("fair_idle", 32'(busy), 0);

        // Single owner on channel 2, request dropped before edge 4.
        req = 4'b0100;
        step();
        check("so_gnt", 32'(gnt), 32'h4);
        check("so_oe", 32'(oe), 1);
        check("so_z", 32'(z_bus), 32'hA5);
        check("so_busy", 32'(busy), 1);
        step();
        step();
        req = 4'b0000;
        step();
        check("so_rel_oe", 32'(oe), 0);
        check("so_rel_z_hiz", 32'(is_hiz(z_bus)), 1);
        check("so_zh", 32'(zh), 32'hA5);
        check("so_turn_busy", 32'(busy), 1);
        step();
        step();
        check("so_idle", 32'(busy), 0);

        // EN dropped in the third DRIVE cycle of channel 1.
        req = 4'b0010;
        step();
        check("en_gnt", 32'(gnt), 32'h2);
        step();
        step();
        en = 1'b0;
        step();
        check("en_rel_oe", 32'(oe), 0);
        check("en_rel_busy", 32'(busy), 1);
        step();
        step();
        step();
        step();
        check("en_nogrant_gnt", 32'(gnt), 0);
        check("en_nogrant_busy", 32'(busy), 0);
        en = 1'b1;
        step();
        check("en_regrant", 32'(gnt), 32'h2);
        req = 4'b0000;
        step();
        step();
        step();
        check("en_idle", 32'(busy), 0);

        // Async reset pulse between edges while channel 2 drives.
        req = 4'b0100;
        step();
        check("ar_pre_oe", 32'(oe), 1);
        check("ar_pre_z", 32'(z_bus), 32'hA5);
        #3;
        rn = 1'b0;
        #1;
        check("ar_z_hiz", 32'(is_hiz(z_bus)), 1);
        check("ar_oe", 32'(oe), 0);
        check("ar_gnt", 32'(gnt), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_zh", 32'(zh), 0);
        req = 4'b0000;
        #2;
        rn = 1'b1;
        step();
        check("ar_first_edge", 32'(gnt), 0);
        req = 4'b1000;
        step();
        check("ar_gnt_after", 32'(gnt), 32'h8);
        req = 4'b0000;
        step();
        step();
        step();

        // Sole requester at MAXB=4: 4 DRIVE, 2 TURN, 1 IDLE, then regrant.
        tbl_gnt  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        tbl_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        req_b = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            step();
            check($sformatf("mb_gnt_c%0d", c), 32'(gnt_b), 32'(tbl_gnt[c]));
            check($sformatf("mb_busy_c%0d", c), 32'(busy_b), 32'(tbl_busy[c]));
            if (c == 0) check("mb_z", 32'(z_b), 32'h5A);
        end

        // Channel 0 hits MAXB with channel 1 pending: channel 1 wins next.
        req_b = 4'b0011;
        for (int c = 0; c < 7; c++) step();
        check("mb_pass_on", 32'(gnt_b), 32'h2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
